// File: rtl/spinner_pkg.sv
// Shared types and helpers for the spinner quadrature decoder.
// Phase encoding is {B,A}; increment order is 00->10->11->01->00.
package spinner_pkg;

    typedef logic [1:0] phase_t;

    typedef enum logic {
        ST_INIT,
        ST_TRACK
    } state_t;

    typedef struct packed {
        logic legal;
        logic dir;
        logic moved;
    } step_t;

    localparam int DELTA_MAX = 127;
    localparam int DELTA_MIN = -128;

    function automatic phase_t inc_of(phase_t r);
        phase_t n;
        case (r)
            2'b00:   n = 2'b10;
            2'b10:   n = 2'b11;
            2'b11:   n = 2'b01;
            default: n = 2'b00;
        endcase
        return n;
    endfunction

    // Classifies the move from reference r to phase p.
    function automatic step_t step_of(phase_t r, phase_t p);
        step_t s;
        s.moved = (p != r);
        s.legal = s.moved && (p != ~r);
        s.dir   = (p == inc_of(r));
        return s;
    endfunction

    function automatic logic [7:0] sat_add(logic [7:0] a, logic [1:0] s);
        logic signed [8:0] sum;
        sum = $signed({a[7], a}) + $signed({{7{s[1]}}, s});
        if (int'(sum) > DELTA_MAX) begin
            return 8'h7F;
        end
        if (int'(sum) < DELTA_MIN) begin
            return 8'h80;
        end
        return sum[7:0];
    endfunction

endpackage

// File: rtl/spinner_phase_filter.sv
// Synchroniser, sample-tick divider and debounce for the spinner phases.
// Emits one accept pulse each time a new phase has been stable FILT_LEN ticks.
module spinner_phase_filter
    import spinner_pkg::*;
#(
    parameter int SAMPLE_DIV = 8,
    parameter int FILT_LEN   = 3
) (
    input  logic       clk_48m,
    input  logic       reset,
    input  logic [1:0] spinner,
    output logic       accept_pulse,
    output logic [1:0] accept_phase
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int FC_W  = $clog2(FILT_LEN + 1);

    phase_t            sync1_q, sync1_d;
    phase_t            sync2_q, sync2_d;
    phase_t            cand_q, cand_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [FC_W-1:0]   filt_cnt_q, filt_cnt_d;
    logic              tick;

    // Next-state for synchroniser, divider and debounce counter.
    always_comb begin
        sync1_d      = spinner;
        sync2_d      = sync1_q;
        tick         = (div_q == DIV_W'(SAMPLE_DIV - 1));
        div_d        = tick ? '0 : div_q + DIV_W'(1);
        cand_d       = cand_q;
        filt_cnt_d   = filt_cnt_q;
        accept_pulse = 1'b0;
        accept_phase = sync2_q;
        if (tick) begin
            if (sync2_q == cand_q) begin
                if (filt_cnt_q < FC_W'(FILT_LEN)) begin
                    filt_cnt_d   = filt_cnt_q + FC_W'(1);
                    accept_pulse = (filt_cnt_q == FC_W'(FILT_LEN - 1));
                end
            end else begin
                cand_d       = sync2_q;
                filt_cnt_d   = FC_W'(1);
                accept_pulse = (FILT_LEN == 1);
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_48m) begin
        if (!reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            cand_q     <= '0;
            div_q      <= '0;
            filt_cnt_q <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            cand_q     <= cand_d;
            div_q      <= div_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

endmodule

// File: rtl/spinner_quadrature_decoder.sv
// 4x quadrature decoder: wrapping position, read-and-clear delta,
// and illegal-jump detection on top of the debounced phase stream.
module spinner_quadrature_decoder
    import spinner_pkg::*;
#(
    parameter int CNT_W      = 12,
    parameter int SAMPLE_DIV = 8,
    parameter int FILT_LEN   = 3
) (
    input  logic             clk_48m,
    input  logic             reset,
    input  logic [1:0]       spinner,
    input  logic             rd_strobe,
    output logic [CNT_W-1:0] pos,
    output logic [7:0]       delta,
    output logic             step_pulse,
    output logic             step_dir,
    output logic             err_pulse,
    output logic [7:0]       err_count
);

    logic       acc_pulse;
    logic [1:0] acc_phase;

    spinner_phase_filter #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .FILT_LEN   (FILT_LEN)
    ) u_filter (
        .clk_48m      (clk_48m),
        .reset        (reset),
        .spinner      (spinner),
        .accept_pulse (acc_pulse),
        .accept_phase (acc_phase)
    );

    state_t           state_q, state_d;
    phase_t           ref_phase_q, ref_phase_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic [7:0]       delta_acc_q, delta_acc_d;
    logic [7:0]       delta_q, delta_d;
    logic [7:0]       err_count_q, err_count_d;
    logic             step_pulse_q, step_pulse_d;
    logic             step_dir_q, step_dir_d;
    logic             err_pulse_q, err_pulse_d;
    step_t            st;
    logic [1:0]       step_v;
    logic [7:0]       acc_sum;

    // Track FSM, counters and read-and-clear of the delta accumulator.
    always_comb begin
        state_d      = state_q;
        ref_phase_d  = ref_phase_q;
        pos_d        = pos_q;
        delta_d      = delta_q;
        err_count_d  = err_count_q;
        step_dir_d   = step_dir_q;
        step_pulse_d = 1'b0;
        err_pulse_d  = 1'b0;
        step_v       = 2'b00;
        st           = step_of(ref_phase_q, acc_phase);
        if (acc_pulse) begin
            unique case (state_q)
                ST_INIT: begin
                    ref_phase_d = acc_phase;
                    state_d     = ST_TRACK;
                end
                ST_TRACK: begin
                    if (st.moved) begin
                        ref_phase_d = acc_phase;
                        if (st.legal) begin
                            step_pulse_d = 1'b1;
                            step_dir_d   = st.dir;
                            pos_d  = st.dir ? pos_q + CNT_W'(1)
                                            : pos_q - CNT_W'(1);
                            step_v = st.dir ? 2'b01 : 2'b11;
                        end else begin
                            err_pulse_d = 1'b1;
                            if (err_count_q != 8'hFF) begin
                                err_count_d = err_count_q + 8'd1;
                            end
                        end
                    end
                end
            endcase
        end
        acc_sum = sat_add(delta_acc_q, step_v);
        if (rd_strobe) begin
            delta_d     = acc_sum;
            delta_acc_d = '0;
        end else begin
            delta_acc_d = acc_sum;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_48m) begin
        if (!reset) begin
            state_q      <= ST_INIT;
            ref_phase_q  <= '0;
            pos_q        <= '0;
            delta_acc_q  <= '0;
            delta_q      <= '0;
            err_count_q  <= '0;
            step_pulse_q <= 1'b0;
            step_dir_q   <= 1'b0;
            err_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ref_phase_q  <= ref_phase_d;
            pos_q        <= pos_d;
            delta_acc_q  <= delta_acc_d;
            delta_q      <= delta_d;
            err_count_q  <= err_count_d;
            step_pulse_q <= step_pulse_d;
            step_dir_q   <= step_dir_d;
            err_pulse_q  <= err_pulse_d;
        end
    end

    assign pos        = pos_q;
    assign delta      = delta_q;
    assign step_pulse = step_pulse_q;
    assign step_dir   = step_dir_q;
    assign err_pulse  = err_pulse_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_spinner_quadrature_decoder.sv
// Directed bench for spinner_quadrature_decoder with an event scoreboard.
// Expected step/error events are queued at drive time, popped on DUT pulses.
module tb_spinner_quadrature_decoder;

    localparam int HOLD = 48;

    logic        clk_48m = 1'b0;
    logic        reset;
    logic [1:0]  spinner;
    logic        rd_strobe;
    logic [11:0] pos;
    logic [7:0]  delta;
    logic        step_pulse;
    logic        step_dir;
    logic        err_pulse;
    logic [7:0]  err_count;

    spinner_quadrature_decoder dut (
        .clk_48m    (clk_48m),
        .reset      (reset),
        .spinner    (spinner),
        .rd_strobe  (rd_strobe),
        .pos        (pos),
        .delta      (delta),
        .step_pulse (step_pulse),
        .step_dir   (step_dir),
        .err_pulse  (err_pulse),
        .err_count  (err_count)
    );

    always #5 clk_48m = ~clk_48m;

    typedef struct {
        logic        err;
        logic        dir;
        logic [11:0] pos;
        logic [7:0]  errc;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    logic [11:0] m_pos;
    logic [1:0]  m_ref;
    int          m_acc;
    int          m_delta;
    int          m_err;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] next_inc(input logic [1:0] p);
        case (p)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] next_dec(input logic [1:0] p);
        case (p)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // Update the model for a new tracked phase and queue the expected event.
    task automatic model_phase(input logic [1:0] p);
        logic dir;
        if (p != m_ref) begin
            if (p == ~m_ref) begin
                if (m_err < 255) m_err++;
                q.push_back('{1'b1, 1'b0, m_pos, 8'(m_err)});
            end else begin
                dir   = (p == next_inc(m_ref));
                m_pos = dir ? m_pos + 12'd1 : m_pos - 12'd1;
                m_acc = m_acc + (dir ? 1 : -1);
                if (m_acc > 127) m_acc = 127;
                if (m_acc < -128) m_acc = -128;
                q.push_back('{1'b0, dir, m_pos, 8'(m_err)});
            end
        end
        m_ref = p;
    endtask

    task automatic drive(input logic [1:0] p);
        @(posedge clk_48m) #1 spinner = p;
        model_phase(p);
        repeat (HOLD) @(posedge clk_48m);
    endtask

    task automatic do_read();
        @(posedge clk_48m) #1 rd_strobe = 1'b1;
        @(posedge clk_48m) #1 rd_strobe = 1'b0;
        m_delta = m_acc;
        m_acc   = 0;
        chk("delta", {24'd0, delta}, {24'd0, 8'(m_delta)});
    endtask

    task automatic do_reset();
        @(posedge clk_48m) #1 reset = 1'b0;
        repeat (4) @(posedge clk_48m);
        #1;
        m_pos = '0; m_acc = 0; m_delta = 0; m_err = 0;
        chk("rst_pos", {20'd0, pos}, 32'd0);
        chk("rst_delta", {24'd0, delta}, 32'd0);
        chk("rst_errc", {24'd0, err_count}, 32'd0);
        chk("rst_step", {31'd0, step_pulse}, 32'd0);
        chk("rst_err", {31'd0, err_pulse}, 32'd0);
        chk("rst_dir", {31'd0, step_dir}, 32'd0);
        reset = 1'b1;
        // INIT absorbs whatever phase is held; no event expected.
        m_ref = spinner;
        repeat (HOLD) @(posedge clk_48m);
        chk("init_pos", {20'd0, pos}, 32'd0);
    endtask

    // Scoreboard: every DUT pulse must match the next queued expectation.
    always @(negedge clk_48m) begin : mon
        exp_t e;
        if (step_pulse || err_pulse) begin
            if (q.size() == 0) begin
                chk("unexpected_event", {30'd0, err_pulse, step_pulse}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("ev_err", {31'd0, err_pulse}, {31'd0, e.err});
                chk("ev_step", {31'd0, step_pulse}, {31'd0, !e.err});
                chk("ev_pos", {20'd0, pos}, {20'd0, e.pos});
                chk("ev_errc", {24'd0, err_count}, {24'd0, e.errc});
                if (!e.err) chk("ev_dir", {31'd0, step_dir}, {31'd0, e.dir});
            end
        end
    end

    initial begin
        logic got;
        reset = 1'b0; spinner = 2'b00; rd_strobe = 1'b0;
        m_pos = '0; m_ref = 2'b00; m_acc = 0; m_delta = 0; m_err = 0;
        repeat (2) @(posedge clk_48m);
        // 1: four increments from 00
        do_reset();
        repeat (4) drive(next_inc(m_ref));
        chk("t1_pos", {20'd0, pos}, {20'd0, m_pos});
        chk("t1_dir", {31'd0, step_dir}, 32'd1);
        do_read();
        // 2: back to 0, then three decrements below zero
        repeat (4) drive(next_dec(m_ref));
        do_read();
        chk("t2_zero", {20'd0, pos}, 32'd0);
        repeat (3) drive(next_dec(m_ref));
        chk("t2_pos", {20'd0, pos}, 32'hFFD);
        do_read();
        do_read();
        // 3: return to 00 and glitch A for one sample tick
        repeat (3) drive(next_inc(m_ref));
        do_read();
        @(posedge clk_48m) #1 spinner = 2'b01;
        repeat (8) @(posedge clk_48m);
        #1 spinner = 2'b00;
        repeat (HOLD) @(posedge clk_48m);
        chk("t3_pos", {20'd0, pos}, {20'd0, m_pos});
        chk("t3_drain", q.size(), 32'd0);
        // 4: illegal jump then a legal increment
        drive(2'b11);
        chk("t4_errc", {24'd0, err_count}, 32'd1);
        chk("t4_pos", {20'd0, pos}, {20'd0, m_pos});
        drive(2'b01);
        do_read();
        // 5: 200 increments, saturating delta
        repeat (200) drive(next_inc(m_ref));
        chk("t5_pos", {20'd0, pos}, {20'd0, m_pos});
        do_read();
        // read held high across the cycle a step commits
        @(posedge clk_48m) #1;
        spinner   = next_inc(m_ref);
        rd_strobe = 1'b1;
        model_phase(spinner);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk_48m) #1;
            if (step_pulse) got = 1'b1;
        end
        rd_strobe = 1'b0;
        chk("coinc_seen", {31'd0, got}, 32'd1);
        m_delta = 1;
        m_acc   = 0;
        chk("coinc_delta", {24'd0, delta}, {24'd0, 8'(m_delta)});
        repeat (HOLD) @(posedge clk_48m);
        do_read();
        // 6: reset at phase 11, then encoder-style -9 moves
        while (m_ref != 2'b11) drive(next_inc(m_ref));
        chk("t6_drain", q.size(), 32'd0);
        do_reset();
        repeat (9) drive(next_dec(m_ref));
        chk("t6_pos", {20'd0, pos}, 32'hFF7);
        do_read();
        repeat (4) @(posedge clk_48m);
        chk("end_drain", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
